// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and counter helpers
package vga_pkg;

    // Counter width shared by x/y and the graphics blocks that consume them.
    localparam int CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    // 640x480 @ 60 Hz horizontal timing, in pixels.
    localparam int H_DISP  = 640;
    localparam int H_FRONT = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;

    // 640x480 @ 60 Hz vertical timing, in lines.
    localparam int V_DISP  = 480;
    localparam int V_FRONT = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;

    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

    // Inclusive sync pulse windows.
    localparam int H_SYNC_START = H_DISP + H_FRONT;
    localparam int H_SYNC_END   = H_DISP + H_FRONT + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISP + V_FRONT;
    localparam int V_SYNC_END   = V_DISP + V_FRONT + V_SYNC - 1;

    // Active-low sync level for a counter value against an inclusive window.
    function automatic logic sync_level(input cnt_t cnt, input cnt_t first, input cnt_t last);
        return !((cnt >= first) && (cnt <= last));
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - mod-DIV clock divider producing a one-clk pixel strobe
module pixel_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    // DIV must be at least 2 so the strobe is low while reset holds the divider at 0.
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

    logic [W-1:0] div_cnt;

    // Divider counts 0..DIV-1 on every clock and restarts from 0 on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters with registered sync outputs
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int DIV = 4,
    parameter int HD  = H_DISP,
    parameter int HF  = H_FRONT,
    parameter int HS  = H_SYNC,
    parameter int HB  = H_BACK,
    parameter int VD  = V_DISP,
    parameter int VF  = V_FRONT,
    parameter int VS  = V_SYNC,
    parameter int VB  = V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick
);

    // Geometry derived from the parameters so non-default builds stay consistent.
    localparam cnt_t LINE_LAST  = cnt_t'(HD + HF + HS + HB - 1);
    localparam cnt_t FRAME_LAST = cnt_t'(VD + VF + VS + VB - 1);
    localparam cnt_t X_DISP     = cnt_t'(HD);
    localparam cnt_t Y_DISP     = cnt_t'(VD);
    localparam cnt_t Y_DISP_END = cnt_t'(VD - 1);
    localparam cnt_t HS_FIRST   = cnt_t'(HD + HF);
    localparam cnt_t HS_LAST    = cnt_t'(HD + HF + HS - 1);
    localparam cnt_t VS_FIRST   = cnt_t'(VD + VF);
    localparam cnt_t VS_LAST    = cnt_t'(VD + VF + VS - 1);

    cnt_t x_next;
    cnt_t y_next;

    pixel_tick_gen #(
        .DIV (DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Next raster position: advance only on pixel ticks, y steps when x wraps.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == LINE_LAST) begin
                x_next = '0;
                if (y == FRAME_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = y + 10'd1;
                end
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Counters and syncs share one register stage; syncs are decoded from the
    // next position so they change on the same edge as x/y and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            x     <= x_next;
            y     <= y_next;
            hsync <= sync_level(x_next, HS_FIRST, HS_LAST);
            vsync <= sync_level(y_next, VS_FIRST, VS_LAST);
        end
    end

    assign video_on   = (x < X_DISP) && (y < Y_DISP);
    assign frame_tick = p_tick && (x == LINE_LAST) && (y == Y_DISP_END);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen, default and small geometries
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;

    logic       hs_a, vs_a, von_a, pt_a, ft_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, von_b, pt_b, ft_b;
    logic [9:0] x_b, y_b;

    int   checks = 0;
    int   errors = 0;
    obs_t qa[$];
    obs_t qb[$];
    int   na = 0;
    int   nb = 0;
    logic phase1 = 1'b0;
    logic line_win = 1'b0;
    int   ft_cnt_b = 0;
    int   hs_low_a = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk        (clk),
        .reset      (rst_a),
        .hsync      (hs_a),
        .vsync      (vs_a),
        .video_on   (von_a),
        .p_tick     (pt_a),
        .x          (x_a),
        .y          (y_a),
        .frame_tick (ft_a)
    );

    vga_sync_gen #(
        .DIV(2), .HD(16), .HF(4), .HS(6), .HB(4),
        .VD(12), .VF(2), .VS(2), .VB(3)
    ) dut_b (
        .clk        (clk),
        .reset      (rst_b),
        .hsync      (hs_b),
        .vsync      (vs_b),
        .video_on   (von_b),
        .p_tick     (pt_b),
        .x          (x_b),
        .y          (y_b),
        .frame_tick (ft_b)
    );

    // Reference: n clocks since the last reset edge fully determine the raster.
    function automatic obs_t model(input int n, input int div,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb);
        obs_t e;
        int ht, vt, p, xi, yi;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        p  = (n / div) % (ht * vt);
        xi = p % ht;
        yi = p / ht;
        e.x   = 10'(xi);
        e.y   = 10'(yi);
        e.hs  = !((xi >= hd + hf) && (xi < hd + hf + hsw));
        e.vs  = !((yi >= vd + vf) && (yi < vd + vf + vsw));
        e.von = (xi < hd) && (yi < vd);
        e.pt  = ((n % div) == div - 1);
        e.ft  = e.pt && (xi == ht - 1) && (yi == vd - 1);
        return e;
    endfunction

    task automatic step(input logic ra, input logic rb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        na = ra ? 0 : na + 1;
        nb = rb ? 0 : nb + 1;
        qa.push_back(model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        qb.push_back(model(nb, 2, 16, 4, 6, 4, 12, 2, 2, 3));
        line_win = phase1 && (na >= 1) && (na <= 3200);
        #1;
    endtask

    // Stimulus: reset, long undisturbed run, then random mid-frame resets.
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        #1;
        repeat (3) step(1'b1, 1'b1);
        phase1 = 1'b1;
        repeat (3600) step(1'b0, 1'b0);
        phase1 = 1'b0;
        line_win = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step($urandom_range(0, 699) == 0, $urandom_range(0, 299) == 0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ft_cnt_b != 3) begin
            errors++;
            $display("FAIL frame_tick_count_b: got %0d required 3", ft_cnt_b);
        end
        checks++;
        if (hs_low_a != 384) begin
            errors++;
            $display("FAIL hsync_low_clks_line0_a: got %0d required 384", hs_low_a);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending required 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: pops one expectation per DUT per cycle and compares away from the edge.
    initial begin
        obs_t e, act;
        logic prev_ok = 1'b0;
        logic prev_hs, prev_vs, prev_pt, prev_rst;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                act = '{x: x_a, y: y_a, hs: hs_a, vs: vs_a, von: von_a, pt: pt_a, ft: ft_a};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL raster_a n=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b required x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
                             na, act.x, act.y, act.hs, act.vs, act.von, act.pt, act.ft,
                             e.x, e.y, e.hs, e.vs, e.von, e.pt, e.ft);
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                act = '{x: x_b, y: y_b, hs: hs_b, vs: vs_b, von: von_b, pt: pt_b, ft: ft_b};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL raster_b n=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b required x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
                             nb, act.x, act.y, act.hs, act.vs, act.von, act.pt, act.ft,
                             e.x, e.y, e.hs, e.vs, e.von, e.pt, e.ft);
                end
                checks++;
                if (x_b >= 10'd30 || y_b >= 10'd19) begin
                    errors++;
                    $display("FAIL range_b: got x=%0d y=%0d required x<30 y<19", x_b, y_b);
                end
                if (prev_ok) begin
                    checks++;
                    if ((hs_b !== prev_hs || vs_b !== prev_vs) && !prev_pt && !prev_rst) begin
                        errors++;
                        $display("FAIL sync_toggle_b: got hs %b->%b vs %b->%b with p_tick=0 required no change",
                                 prev_hs, hs_b, prev_vs, vs_b);
                    end
                end
                prev_ok  = 1'b1;
                prev_hs  = hs_b;
                prev_vs  = vs_b;
                prev_pt  = pt_b;
                prev_rst = rst_b;
            end
            if (phase1 && ft_b === 1'b1) ft_cnt_b++;
            if (line_win && hs_a === 1'b0) hs_low_a++;
        end
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
- REQ-001 SHALL have parameter DIV, default 4, meaning system clocks per pixel tick (100 MHz to 25 MHz).
- REQ-002 SHALL have parameters HD=640, HF=16, HS=96, HB=48, VD=480, VF=10, VS=2, VB=33, meaning display/front porch/sync/back porch lengths in pixels or lines.
- REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
- REQ-005 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
- REQ-006 SHALL have port vsync, output, 1 bit: vertical sync, active low.
- REQ-007 SHALL have port video_on, output, 1 bit: current pixel is in the display area.
- REQ-008 SHALL have port p_tick, output, 1 bit: one-clk pixel strobe.
- REQ-009 SHALL have port x, output, 10 bits: horizontal pixel count.
- REQ-010 SHALL have port y, output, 10 bits: vertical line count.
- REQ-011 SHALL have port frame_tick, output, 1 bit: one-clk pulse at the end of the visible frame.

Function
- REQ-012 SHALL count a mod-DIV divider 0..DIV-1 every clk; p_tick SHALL be 1 for exactly one clk when the divider equals DIV-1.
- REQ-013 SHALL advance the counters only on clks with p_tick=1; x and y SHALL hold on all other clks.
- REQ-014 x SHALL count 0..H_TOTAL-1 (H_TOTAL=HD+HF+HS+HB=800), then wrap to 0.
- REQ-015 y SHALL increment only on the tick where x wraps, counting 0..V_TOTAL-1 (V_TOTAL=525), then wrap to 0 on the same tick as x wraps.
- REQ-016 video_on SHALL be combinational: (x<HD)&&(y<VD).
- REQ-017 hsync SHALL be 0 iff HD+HF <= x <= HD+HF+HS-1 (656..751).
- REQ-018 vsync SHALL be 0 iff VD+VF <= y <= VD+VF+VS-1 (490..491).
- REQ-019 hsync and vsync SHALL be registered, computed from next-state counter values, so they are cycle-aligned with x/y with no combinational glitches.
- REQ-020 frame_tick SHALL be 1 for one clk when p_tick=1, x=799 and y=479, i.e. the clk before y becomes 480.
- REQ-021 x and y SHALL never take values >= H_TOTAL or >= V_TOTAL, respectively.
- REQ-022 Counter arithmetic SHALL be unsigned 10-bit.

Reset
- REQ-023 While reset=1 at a clk edge: divider=0, x=0, y=0, hsync=1, vsync=1, p_tick=0, frame_tick=0; video_on follows as 1.
- REQ-024 Reset asserted mid-frame SHALL take effect at the next edge regardless of p_tick.
- REQ-025 The first p_tick after reset release SHALL occur DIV-1 clks after the release edge.

Structure
- REQ-026 Timing constants (HD..VB, H_TOTAL, V_TOTAL, sync start/end) SHALL live in shared package vga_pkg, also used by the graphics blocks.
- REQ-027 The divider SHALL be sub-module pixel_tick_gen (ports clk, reset, p_tick; parameter DIV).
- REQ-028 The implementation SHALL contain no other sub-modules.

Verification
- REQ-029 Release reset and run 12 clks -> p_tick high on clks 3, 7, 11 only; x=1, 2, 3 after each; y=0.
- REQ-030 Run one line (3200 clks) -> hsync low for exactly 96 ticks starting at x=656; video_on low from x=640; x wraps 799->0 and y goes 0->1.
- REQ-031 Run a full frame (1,680,000 clks) -> vsync low during y=490..491 only; frame_tick exactly once, at x=799, y=479; counters return to 0,0.
- REQ-032 Assert reset at x=700, y=300 -> next clk x=0, y=0, hsync=1, vsync=1, p_tick=0.
- REQ-033 Run 3 frames with assertions -> x<800 and y<525 always; hsync/vsync never toggle on a clk with p_tick=0.
- REQ-034 Build with DIV=2 -> p_tick every second clk; line period 1600 clks.
